// File: rtl/cordic_shift_seq.sv
// Iteration sequencer for the CORDIC shifters: one (i, m) beat per micro-iteration with valid/ready.
// Define CORDIC_HYP_REPEAT_EN to repeat hyperbolic indices 4 and 13 for convergence.
module cordic_shift_seq #(
  parameter int N_ITER = 15,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             mode_in,
  input  logic             abort,
  output logic [IDX_W-1:0] iter_i,
  output logic             iter_m,
  output logic             iter_valid,
  input  logic             iter_ready,
  output logic             iter_first,
  output logic             iter_last,
  output logic [4:0]       beat_cnt,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_I = IDX_W'(N_ITER);

  state_t state;
  state_t state_nxt;
  logic   accept;
  logic   fire;
  logic   need_rep;
  logic   at_end;

`ifdef CORDIC_HYP_REPEAT_EN
  // High while the current beat is the second issue of a repeated index.
  logic rep;

  assign need_rep = iter_m && !rep && (iter_i == IDX_W'(4) || iter_i == IDX_W'(13));

  always_ff @(posedge clk) begin
    if (rst) begin
      rep <= 1'b0;
    end else if (accept) begin
      rep <= 1'b0;
    end else if (fire) begin
      rep <= need_rep;
    end
  end
`else
  assign need_rep = 1'b0;
`endif

  assign at_end = (iter_i == LAST_I) && !need_rep;
  assign accept = (state == IDLE) && start_valid;
  assign fire   = (state == RUN) && iter_ready && !abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    start_ready = 1'b0;
    iter_valid  = 1'b0;
    iter_last   = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
        if (start_valid) state_nxt = RUN;
      end
      RUN: begin
        iter_valid = 1'b1;
        iter_last  = at_end;
        // abort wins over a simultaneous handshake
        if (abort) begin
          state_nxt = IDLE;
        end else if (iter_ready && at_end) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iter_i     <= '0;
      iter_m     <= 1'b0;
      iter_first <= 1'b0;
      beat_cnt   <= '0;
    end else if (accept) begin
      iter_i     <= IDX_W'(1);
      iter_m     <= mode_in;
      iter_first <= 1'b1;
      beat_cnt   <= '0;
    end else if (fire) begin
      beat_cnt   <= beat_cnt + 5'd1;
      iter_first <= 1'b0;
      // a repeat keeps the same index for one more beat
      if (!at_end && !need_rep) iter_i <= iter_i + IDX_W'(1);
    end
  end

endmodule

// File: doc/cordic_shift_seq.md
Name: cordic_shift_seq

Overview:
- Iteration sequencer that drives the shift-index/mode interface of the CORDIC datapath shifters (inputs m, i).
- Accepts one job per handshake and emits one (i, m) beat per CORDIC micro-iteration, with valid/ready flow control.
- Signals first and last beats and pulses done at job end.
- Sits between the NN layer controller and the CORDIC MAC/activation datapath.

Parameters:
- N_ITER, 15, iterations per job; legal range 1..15; i runs 1..N_ITER.
- IDX_W, 4, width of iter_i; fixed to match the shifter's 4-bit i port.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- start_valid  in  1  job request.
- start_ready  out  1  high only in IDLE.
- mode_in  in  1  job mode, sampled at accept; 1 = hyperbolic, 0 = linear.
- abort  in  1  cancels the job in flight.
- iter_i  out  IDX_W  shift index to the shifter i port.
- iter_m  out  1  mode to the shifter m port.
- iter_valid  out  1  beat present.
- iter_ready  in  1  datapath consumes the beat.
- iter_first  out  1  current beat is the first of the job.
- iter_last  out  1  current beat is the last of the job.
- beat_cnt  out  5  beats accepted so far in this job.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse at job completion.

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - state=IDLE.
  - iter_i=0, iter_m=0, iter_valid=0, iter_first=0, iter_last=0, beat_cnt=0, busy=0, done=0.
  - start_ready=1 from the first cycle after reset.
  - A reset mid-job discards the job; no done pulse.
- States:
  - IDLE: start_ready=1. On start_valid&start_ready, latch mode_in into iter_m, set iter_i=1 and iter_first=1, go to RUN. The first beat is valid the cycle after accept (latency 1).
  - RUN: iter_valid=1. The beat is held stable (i, m, first, last) while iter_ready=0.
    - On iter_valid&iter_ready: beat_cnt increments and iter_first clears.
    - If the beat was last, go to DONE; otherwise advance to the next index.
  - DONE: iter_valid=0 and done=1 for exactly one cycle, then IDLE. beat_cnt holds its final value until the next accept, which clears it to 0.
- Index sequence:
  - Linear (m=0): i = 1,2,…,N_ITER, giving N_ITER beats. The shifter applies a shift of i-1, so the effective shifts are 0..N_ITER-1.
  - Hyperbolic (m=1): i = 1..N_ITER, with repeat beats per the optional feature. The shifter applies a shift of i.
- iter_last is high on the final beat of the sequence, including when that beat is a repeat.
- abort:
  - Sampled in RUN; takes priority over iter_ready.
  - On abort the block goes straight to IDLE the next cycle with iter_valid=0. No done pulse; beat_cnt is held.
  - abort in IDLE or DONE is ignored.
- Simultaneous events:
  - start_valid during RUN/DONE is not accepted (start_ready=0).
  - A start accepted in IDLE the cycle after DONE is legal, giving back-to-back jobs with one idle cycle between them.
  - rst overrides everything.
- N_ITER=1 means one beat with iter_first=iter_last=1. Hyperbolic mode needs i≥1, so no i=0 beat is ever issued.
- Counters must not wrap: the maximum is 17 beats, which fits in 5 bits.

Optional Feature:
- Macro: CORDIC_HYP_REPEAT_EN.
- Defined: in hyperbolic mode, indices 4 and 13 (when ≤N_ITER) are each issued twice on consecutive beats, for convergence.
  - The repeat beat has identical iter_i and iter_first=0.
  - Job length is N_ITER+1 beats when 4≤N_ITER<13, and N_ITER+2 beats when N_ITER≥13.
- Undefined: no repeats; hyperbolic length is N_ITER beats. Linear mode is unaffected either way.

Test Plan:
- Linear, N_ITER=15, iter_ready=1 constantly, mode_in=0:
  - iter_i=1..15 on 15 consecutive cycles starting 1 cycle after accept.
  - iter_last on i=15, done one cycle later, beat_cnt=15.
- Hyperbolic with CORDIC_HYP_REPEAT_EN, N_ITER=15:
  - Sequence 1,2,3,4,4,5,…,12,13,13,14,15 (17 beats), iter_m=1 throughout, beat_cnt=17.
  - Same stimulus without the macro gives 15 beats.
- Backpressure: toggle iter_ready 1,0,0,1 repeatedly on a linear job:
  - Outputs hold stable while ready=0.
  - No index skipped or duplicated; done after 15 accepted beats.
- Abort on beat i=6, with iter_ready=1 in the same cycle:
  - IDLE next cycle, iter_valid=0, no done pulse, beat_cnt=5.
  - start_ready=1 on the following cycle.
- rst asserted on beat i=9 of a hyperbolic job:
  - All outputs reach their reset values after the edge, with no done pulse.
  - A new linear job then starts cleanly at i=1.
- N_ITER=1, linear, then an immediate second job:
  - One beat with i=1 and first=last=1, then done.
  - start_ready=1 in the next cycle; the second job is accepted and is also a single beat.
